dac_wave_seq: RTL and testbench
===============================

Name: dac_wave_seq

Overview:
Waveform playback sequencer that drives the AD5791 controller's TX sample port and its start input. It reads samples from a waveform RAM starting at a programmed base address and pushes them one at a time into the controller's TX FIFO. It paces DAC updates with a programmable sample-rate tick and supports finite or infinite looping, stop, and underrun counting.

Parameters:
DATA_NBIT, 20, sample width; matches the DAC data width.
ADDR_NBIT, 10, waveform RAM address width.
RATE_NBIT, 16, width of the sample-period register.
URUN_NBIT, 8, width of the underrun counter.

Ports:
mclk  input  1  main clock; also clocks the DAC controller.
rst  input  1  synchronous, active-high reset.
cfg_start  input  1  1-cycle pulse; latches cfg_* and starts playback (ignored while busy).
cfg_stop  input  1  1-cycle pulse; aborts playback.
cfg_base  input  ADDR_NBIT  first RAM address.
cfg_len  input  ADDR_NBIT  number of samples minus 1.
cfg_loops  input  8  number of passes; 0 = infinite.
cfg_rate  input  RATE_NBIT  sample period minus 1, in mclk cycles; values below 3 are treated as 3.
ram_rd  output  1  RAM read strobe.
ram_addr  output  ADDR_NBIT  RAM read address.
ram_rdata  input  DATA_NBIT  RAM data, valid exactly 1 cycle after ram_rd.
tx_dv  output  1  sample valid to the DAC TX FIFO.
tx_data  output  DATA_NBIT  sample to the DAC TX FIFO.
tx_waitrequest  input  1  FIFO full.
dac_start  output  1  1-cycle pulse to the DAC controller start input.
busy  output  1  high from start acceptance until return to IDLE.
done  output  1  1-cycle pulse on normal completion (not on stop).
underrun_cnt  output  URUN_NBIT  saturating count of late samples; cleared on accepted cfg_start.

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; counters are cleared. Reset mid-operation abandons everything immediately, including a pending tx_dv. It is the only exception to the no-retract rule.
- States:
  - IDLE.
  - FETCH: ram_rd=1 for 1 cycle, ram_addr = (cfg_base + offset) mod 2^ADDR_NBIT.
  - LOAD: capture ram_rdata into tx_data.
  - PUSH: tx_dv=1.
  - ARM: wait for the rate tick.
- Start: cfg_start in IDLE latches the config, sets offset=0, sets pass=1, clears the rate counter and underrun_cnt, sets busy=1, then goes to FETCH. cfg_start while busy is ignored.
- Handshake:
  - A word is accepted on a rising edge where tx_dv=1 and tx_waitrequest=0.
  - tx_dv and tx_data stay stable until accepted; tx_dv is never retracted once asserted.
  - After acceptance, tx_dv=0 the next cycle and the FSM moves to ARM.
- Rate counter:
  - Runs continuously while busy: 0..rate_l, then wraps.
  - tick = (cnt == rate_l), where rate_l = max(cfg_rate, 3).
  - The first tick occurs rate_l+1 cycles after start acceptance.
- Tick in ARM:
  - dac_start pulses in the same cycle as the tick.
  - If offset == cfg_len: offset=0, pass+1, and if cfg_loops != 0 and pass == cfg_loops, go to DONE; otherwise go to FETCH.
  - Otherwise offset+1, then FETCH.
- Tick in FETCH, LOAD or PUSH (sample not yet in the FIFO): underrun_cnt increments, saturating at all-ones. No dac_start is issued. The FSM continues, and the late sample fires on the next tick after acceptance.
- DONE: done=1 and busy=0 for 1 cycle, then IDLE. done and the final dac_start are in different cycles; done follows 1 cycle later.
- Stop:
  - cfg_stop while busy goes to IDLE next cycle with busy=0 and no done.
  - Exception: if tx_dv=1 and the word is not yet accepted, the FSM stays in PUSH until acceptance, then goes to IDLE without dac_start.
  - cfg_stop in IDLE is ignored.
  - cfg_stop and a tick in the same cycle: stop wins, no dac_start.
- Simultaneous cfg_start and cfg_stop in IDLE: start wins.
- Minimum sample loop (FETCH, LOAD, PUSH, ARM) is 4 cycles; this is why rate_l >= 3.

Test Plan:
1. Pattern playback: base=0x3FE, len=3, loops=1, rate=9, RAM[a]=a, waitrequest=0 -> ram_addr 0x3FE, 0x3FF, 0x000, 0x001; tx_data in the same order; 4 dac_start pulses spaced 10 cycles, first at cycle 10; done pulses 1 cycle after the 4th; underrun_cnt=0.
2. Looping: len=1, loops=3, rate=5 -> 6 dac_start pulses, then done; loops=0 runs indefinitely until cfg_stop; done never asserts.
3. Backpressure: hold tx_waitrequest=1 for 25 cycles during PUSH with rate=9 -> tx_dv and tx_data stable throughout; underrun_cnt=2; dac_start on the first tick after release.
4. Stop during PUSH with waitrequest=1 -> busy stays 1 until acceptance, then busy=0; no done, no further dac_start or ram_rd.
5. Stop coincident with a tick -> no dac_start that cycle; IDLE next cycle. cfg_start while busy -> ignored, config unchanged.
6. Boundaries: rate=0 gives 4-cycle spacing; rst asserted during PUSH clears tx_dv, busy and underrun_cnt next cycle; 300 forced underruns with URUN_NBIT=8 saturate underrun_cnt at 255.

Source files
------------

// File: rtl/dac_wave_seq.sv
// Waveform playback sequencer: RAM -> AD5791 TX FIFO, paced by a sample-rate tick.
// Latency: first dac_start rate_l+1 cycles after start; backpressure holds tx_dv until accepted.
module dac_wave_seq #(
    parameter int DATA_NBIT = 20,
    parameter int ADDR_NBIT = 10,
    parameter int RATE_NBIT = 16,
    parameter int URUN_NBIT = 8
) (
    input  logic                 mclk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic                 cfg_stop,
    input  logic [ADDR_NBIT-1:0] cfg_base,
    input  logic [ADDR_NBIT-1:0] cfg_len,
    input  logic [7:0]           cfg_loops,
    input  logic [RATE_NBIT-1:0] cfg_rate,
    output logic                 ram_rd,
    output logic [ADDR_NBIT-1:0] ram_addr,
    input  logic [DATA_NBIT-1:0] ram_rdata,
    output logic                 tx_dv,
    output logic [DATA_NBIT-1:0] tx_data,
    input  logic                 tx_waitrequest,
    output logic                 dac_start,
    output logic                 busy,
    output logic                 done,
    output logic [URUN_NBIT-1:0] underrun_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PUSH,
        S_ARM,
        S_DONE
    } state_t;

    localparam logic [RATE_NBIT-1:0] RATE_MIN = RATE_NBIT'(3);

    state_t               state;
    state_t               state_nx;
    logic [ADDR_NBIT-1:0] base_l;
    logic [ADDR_NBIT-1:0] len_l;
    logic [7:0]           loops_l;
    logic [RATE_NBIT-1:0] rate_l;
    logic [ADDR_NBIT-1:0] offset;
    logic [7:0]           pass;
    logic [RATE_NBIT-1:0] cnt;
    logic                 stop_pend;
    logic                 tick;
    logic                 accept;
    logic                 start_ok;
    logic                 last;
    logic                 late;

    assign busy     = (state == S_FETCH) || (state == S_LOAD) ||
                      (state == S_PUSH)  || (state == S_ARM);
    assign tick     = busy && (cnt == rate_l);
    assign tx_dv    = (state == S_PUSH);
    assign accept   = tx_dv && !tx_waitrequest;
    assign start_ok = (state == S_IDLE) && cfg_start;
    assign last     = (offset == len_l);
    assign late     = (state == S_FETCH) || (state == S_LOAD) || (state == S_PUSH);
    assign ram_rd   = (state == S_FETCH);
    assign ram_addr = ram_rd ? (base_l + offset) : '0;
    assign done     = (state == S_DONE);

    always_ff @(posedge mclk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        dac_start = 1'b0;
        case (state)
            S_IDLE: begin
                if (cfg_start) state_nx = S_FETCH;
            end
            S_FETCH: begin
                state_nx = cfg_stop ? S_IDLE : S_LOAD;
            end
            S_LOAD: begin
                state_nx = cfg_stop ? S_IDLE : S_PUSH;
            end
            S_PUSH: begin
                // A word already offered to the FIFO must complete before a stop takes effect.
                if (accept) state_nx = (cfg_stop || stop_pend) ? S_IDLE : S_ARM;
            end
            S_ARM: begin
                if (cfg_stop) begin
                    state_nx = S_IDLE;
                end else if (tick) begin
                    dac_start = 1'b1;
                    if (last && (loops_l != 8'd0) && (pass == loops_l)) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            base_l  <= '0;
            len_l   <= '0;
            loops_l <= '0;
            rate_l  <= RATE_MIN;
        end else if (start_ok) begin
            base_l  <= cfg_base;
            len_l   <= cfg_len;
            loops_l <= cfg_loops;
            rate_l  <= (cfg_rate < RATE_MIN) ? RATE_MIN : cfg_rate;
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            offset <= '0;
            pass   <= '0;
        end else if (start_ok) begin
            offset <= '0;
            pass   <= 8'd1;
        end else if (dac_start) begin
            if (last) begin
                offset <= '0;
                pass   <= pass + 8'd1;
            end else begin
                offset <= offset + ADDR_NBIT'(1);
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            cnt <= '0;
        end else if (start_ok) begin
            cnt <= '0;
        end else if (busy) begin
            cnt <= tick ? '0 : cnt + RATE_NBIT'(1);
        end
    end

    // A tick that finds the sample not yet in the FIFO is an underrun.
    always_ff @(posedge mclk) begin
        if (rst) begin
            underrun_cnt <= '0;
        end else if (start_ok) begin
            underrun_cnt <= '0;
        end else if (tick && late && (underrun_cnt != '1)) begin
            underrun_cnt <= underrun_cnt + URUN_NBIT'(1);
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            tx_data <= '0;
        end else if (state == S_LOAD) begin
            tx_data <= ram_rdata;
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            stop_pend <= 1'b0;
        end else begin
            stop_pend <= (state == S_PUSH) && !accept && (stop_pend || cfg_stop);
        end
    end

endmodule

// File: tb/tb_dac_wave_seq.sv
// Scoreboard bench for dac_wave_seq: expected RAM addresses, TX words,
// dac_start and done cycles are queued at stimulus time and popped by a monitor.
module tb_dac_wave_seq;

    localparam int DN = 20;
    localparam int AN = 10;
    localparam int RN = 16;
    localparam int UN = 8;

    logic          mclk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_start = 1'b0;
    logic          cfg_stop = 1'b0;
    logic [AN-1:0] cfg_base = '0;
    logic [AN-1:0] cfg_len = '0;
    logic [7:0]    cfg_loops = '0;
    logic [RN-1:0] cfg_rate = '0;
    logic          ram_rd;
    logic [AN-1:0] ram_addr;
    logic [DN-1:0] ram_rdata = '0;
    logic          tx_dv;
    logic [DN-1:0] tx_data;
    logic          tx_waitrequest = 1'b0;
    logic          dac_start;
    logic          busy;
    logic          done;
    logic [UN-1:0] underrun_cnt;

    dac_wave_seq #(
        .DATA_NBIT(DN), .ADDR_NBIT(AN), .RATE_NBIT(RN), .URUN_NBIT(UN)
    ) dut (
        .mclk(mclk), .rst(rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_loops(cfg_loops), .cfg_rate(cfg_rate),
        .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .tx_dv(tx_dv), .tx_data(tx_data), .tx_waitrequest(tx_waitrequest),
        .dac_start(dac_start), .busy(busy), .done(done), .underrun_cnt(underrun_cnt)
    );

    always #5 mclk = ~mclk;

    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    logic [DN-1:0] ram_xor = '0;
    logic          hold_chk = 1'b0;
    logic [DN-1:0] hold_data = '0;

    logic [AN-1:0] addr_q[$];
    logic [DN-1:0] data_q[$];
    int            dac_q[$];
    int            done_q[$];

    always @(posedge mclk) cyc <= cyc + 1;

    always @(posedge mclk) if (ram_rd) ram_rdata <= {{(DN-AN){1'b0}}, ram_addr} ^ ram_xor;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DN-1:0] exp_data(input logic [AN-1:0] a);
        return {{(DN-AN){1'b0}}, a} ^ ram_xor;
    endfunction

    task automatic expect_samples(input logic [AN-1:0] base, input int len, input int n);
        for (int k = 0; k < n; k++) begin
            logic [AN-1:0] a;
            a = base + AN'(k % (len + 1));
            addr_q.push_back(a);
            data_q.push_back(exp_data(a));
        end
    endtask

    // Every wait clears the one-cycle control pulses it passes over.
    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(negedge mclk);
            cfg_start = 1'b0;
            cfg_stop  = 1'b0;
        end
    endtask

    task automatic start_play(input logic [AN-1:0] base, input logic [AN-1:0] len,
                              input logic [7:0] loops, input logic [RN-1:0] rate,
                              output int s);
        @(negedge mclk);
        cfg_base  = base;
        cfg_len   = len;
        cfg_loops = loops;
        cfg_rate  = rate;
        cfg_start = 1'b1;
        s = cyc;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            wait_until(cyc + 1);
            n++;
        end while (busy && n < budget);
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic drain_check(input string tag);
        wait_until(cyc + 15);
        check({tag, "_addr_left"}, addr_q.size(), 0);
        check({tag, "_data_left"}, data_q.size(), 0);
        check({tag, "_dac_left"}, dac_q.size(), 0);
        check({tag, "_done_left"}, done_q.size(), 0);
        addr_q.delete();
        data_q.delete();
        dac_q.delete();
        done_q.delete();
    endtask

    always @(posedge mclk) begin
        hold_chk  <= tx_dv && tx_waitrequest && !rst;
        hold_data <= tx_data;
    end

    always @(negedge mclk) begin
        if (ram_rd) begin
            if (addr_q.size() == 0) check("ram_rd_extra", 32'd1, 32'd0);
            else check("ram_addr", 32'(ram_addr), 32'(addr_q.pop_front()));
        end
        if (tx_dv && !tx_waitrequest) begin
            if (data_q.size() == 0) check("tx_extra", 32'd1, 32'd0);
            else check("tx_data", 32'(tx_data), 32'(data_q.pop_front()));
        end
        if (hold_chk) check("tx_hold", {11'd0, tx_dv, tx_data}, {11'd0, 1'b1, hold_data});
        if (dac_start) begin
            if (dac_q.size() == 0) check("dac_start_extra", 32'd1, 32'd0);
            else check("dac_start_cyc", 32'(cyc), 32'(dac_q.pop_front()));
        end
        if (done) begin
            if (done_q.size() == 0) check("done_extra", 32'd1, 32'd0);
            else check("done_cyc", 32'(cyc), 32'(done_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;

        // Reset state
        wait_until(3);
        check("rst_ram", {ram_rd, 21'd0, ram_addr}, 32'd0);
        check("rst_tx", {tx_dv, 11'd0, tx_data}, 32'd0);
        check("rst_ctl", {dac_start, busy, done}, 32'd0);
        check("rst_urun", 32'(underrun_cnt), 32'd0);
        rst = 1'b0;
        wait_until(5);

        // Pattern playback with address wrap, RAM[a] = a
        ram_xor = '0;
        start_play(10'h3FE, 10'd3, 8'd1, 16'd9, s);
        expect_samples(10'h3FE, 3, 4);
        for (int k = 1; k <= 4; k++) dac_q.push_back(s + 10 * k);
        done_q.push_back(s + 41);
        wait_until(s + 1);
        check("t1_busy", 32'(busy), 32'd1);
        wait_idle(100);
        check("t1_urun", 32'(underrun_cnt), 32'd0);
        drain_check("t1");

        // Finite looping
        ram_xor = 20'hA5C3F;
        start_play(10'h100, 10'd1, 8'd3, 16'd5, s);
        expect_samples(10'h100, 1, 6);
        for (int k = 1; k <= 6; k++) dac_q.push_back(s + 6 * k);
        done_q.push_back(s + 37);
        wait_idle(100);
        drain_check("t2a");

        // Infinite looping, stopped in ARM
        start_play(10'h100, 10'd1, 8'd0, 16'd5, s);
        expect_samples(10'h100, 1, 5);
        for (int k = 1; k <= 4; k++) dac_q.push_back(s + 6 * k);
        wait_until(s + 28);
        cfg_stop = 1'b1;
        wait_until(s + 29);
        check("t2b_busy", 32'(busy), 32'd0);
        drain_check("t2b");

        // Backpressure across two ticks
        start_play(10'h010, 10'd1, 8'd1, 16'd9, s);
        expect_samples(10'h010, 1, 2);
        dac_q.push_back(s + 30);
        dac_q.push_back(s + 40);
        done_q.push_back(s + 41);
        wait_until(s + 2);
        tx_waitrequest = 1'b1;
        wait_until(s + 27);
        tx_waitrequest = 1'b0;
        wait_idle(100);
        check("t3_urun", 32'(underrun_cnt), 32'd2);
        drain_check("t3");

        // Stop while a word is held by backpressure
        start_play(10'h020, 10'd3, 8'd0, 16'd9, s);
        expect_samples(10'h020, 3, 1);
        wait_until(s + 2);
        tx_waitrequest = 1'b1;
        wait_until(s + 5);
        cfg_stop = 1'b1;
        wait_until(s + 8);
        check("t4_busy_held", 32'(busy), 32'd1);
        tx_waitrequest = 1'b0;
        wait_until(s + 9);
        check("t4_busy_rel", 32'(busy), 32'd0);
        drain_check("t4");

        // Start while busy is ignored; stop coincident with a tick
        start_play(10'h030, 10'd3, 8'd0, 16'd4, s);
        expect_samples(10'h030, 3, 2);
        dac_q.push_back(s + 5);
        wait_until(s + 3);
        cfg_base  = 10'h3A0;
        cfg_len   = 10'd0;
        cfg_rate  = 16'd20;
        cfg_start = 1'b1;
        wait_until(s + 10);
        cfg_stop = 1'b1;
        wait_until(s + 11);
        check("t5_busy", 32'(busy), 32'd0);
        drain_check("t5");

        // rate=0 clamps to a 4-cycle sample period
        start_play(10'h200, 10'd2, 8'd1, 16'd0, s);
        expect_samples(10'h200, 2, 3);
        for (int k = 1; k <= 3; k++) dac_q.push_back(s + 4 * k);
        done_q.push_back(s + 13);
        wait_idle(100);
        drain_check("t6a");

        // Reset during PUSH abandons the pending word
        start_play(10'h040, 10'd3, 8'd0, 16'd9, s);
        addr_q.push_back(10'h040);
        wait_until(s + 2);
        tx_waitrequest = 1'b1;
        wait_until(s + 12);
        check("t6b_urun_pre", 32'(underrun_cnt), 32'd1);
        check("t6b_dv_pre", 32'(tx_dv), 32'd1);
        rst = 1'b1;
        wait_until(s + 13);
        check("t6b_dv", 32'(tx_dv), 32'd0);
        check("t6b_busy", 32'(busy), 32'd0);
        check("t6b_urun", 32'(underrun_cnt), 32'd0);
        rst = 1'b0;
        tx_waitrequest = 1'b0;
        drain_check("t6b");

        // Underrun counter saturation
        tx_waitrequest = 1'b1;
        start_play(10'h050, 10'd0, 8'd0, 16'd0, s);
        expect_samples(10'h050, 0, 1);
        wait_until(s + 1018);
        check("t6c_urun_254", 32'(underrun_cnt), 32'd254);
        wait_until(s + 1022);
        check("t6c_urun_255", 32'(underrun_cnt), 32'd255);
        wait_until(s + 1210);
        check("t6c_urun_sat", 32'(underrun_cnt), 32'd255);
        cfg_stop = 1'b1;
        wait_until(s + 1212);
        check("t6c_busy_held", 32'(busy), 32'd1);
        tx_waitrequest = 1'b0;
        wait_until(s + 1213);
        check("t6c_busy_rel", 32'(busy), 32'd0);
        drain_check("t6c");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
